// File: rtl/spram_pkg.sv
// Shared definitions for the single-port-RAM FIFO controller: default widths
// and the push/pop arbitration priority.
package spram_pkg;

    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 4;
    localparam int DEPTH_DEF = 2 ** AW_DEF;

    typedef enum logic {
        PRI_WRITE = 1'b0,
        PRI_READ  = 1'b1
    } pri_e;

    function automatic pri_e pri_flip(input pri_e p);
        return (p == PRI_WRITE) ? PRI_READ : PRI_WRITE;
    endfunction

endpackage

// File: rtl/spram_fifo_ctrl_if.sv
// Push/pop handshake bundle between producers/consumers and the FIFO controller.
interface spram_fifo_ctrl_if
    import spram_pkg::*;
#(
    parameter int DW = DW_DEF
);

    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/spram_arb.sv
// Grant logic for the single RAM port; the priority flips only when both a
// push and a pop want the port in the same cycle.
module spram_arb
    import spram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic wreq,
    input  logic rreq,
    output logic wgnt,
    output logic rgnt
);

    pri_e pri;
    pri_e pri_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pri <= PRI_WRITE;
        end else begin
            pri <= pri_nxt;
        end
    end

    always_comb begin
        wgnt    = 1'b0;
        rgnt    = 1'b0;
        pri_nxt = pri;
        if (wreq && rreq) begin
            wgnt    = (pri == PRI_WRITE);
            rgnt    = (pri == PRI_READ);
            pri_nxt = pri_flip(pri);
        end else begin
            wgnt = wreq;
            rgnt = rreq;
        end
    end

endmodule

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller owning the only port of a single-port RAM with registered
// dout; one word is staged in an output register for the consumer.
module spram_fifo_ctrl
    import spram_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    spram_fifo_ctrl_if.slave  bus,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    localparam int          DEPTH   = 2 ** AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          rd_inflight;
    logic          rd_vld_p1;
    logic [DW-1:0] rd_data_p1;

    logic wreq;
    logic rreq;
    logic wgnt;
    logic rgnt;

    // Requests are masked during reset so nothing touches the RAM port.
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0) && !rd_vld_p1 && !rd_inflight;
    assign wreq  = !rst && bus.wr_valid && !full;
    assign rreq  = !rst && (count != '0) && !rd_inflight && (!rd_vld_p1 || bus.rd_ready);

    spram_arb u_arb (
        .clk  (clk),
        .rst  (rst),
        .wreq (wreq),
        .rreq (rreq),
        .wgnt (wgnt),
        .rgnt (rgnt)
    );

    assign bus.wr_ready = wgnt;
    assign ram_we       = wgnt;
    assign ram_addr     = wgnt ? wptr : rptr;
    assign ram_din      = wgnt ? bus.wr_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wgnt) begin
                wptr  <= wptr + 1'b1;
                count <= count + 1'b1;
            end else if (rgnt) begin
                rptr  <= rptr + 1'b1;
                count <= count - 1'b1;
            end
        end
    end

    // Stage p0 -> p1: RAM return lands in the output register one cycle after issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_inflight <= 1'b0;
            rd_vld_p1   <= 1'b0;
            rd_data_p1  <= '0;
        end else begin
            rd_inflight <= rgnt;
            if (rd_inflight) begin
                rd_vld_p1  <= 1'b1;
                rd_data_p1 <= ram_dout;
            end else if (rd_vld_p1 && bus.rd_ready) begin
                rd_vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.rd_valid = rd_vld_p1;
    assign bus.rd_data  = rd_data_p1;

endmodule
